cos_lut_arbiter: RTL and testbench

Round-robin scheduler that shares one cosine look-up table between four requesters in the LogTFLAF functional-expansion path. Each cycle it grants at most one requester, drives the 2-bit select of the bit-sliced 4:1 address mux feeding the LUT, and enables the LUT read. A tag pipeline tracks each read so the returned cosine sample reaches the requester that issued it. Sustained throughput is one lookup per cycle.

---
 rtl/cos_arb_pkg.sv | 18 +
 rtl/cos_tag_pipe.sv | 38 +++
 rtl/cos_lut_arbiter.sv | 120 ++++++++++++
 tb/tb_cos_lut_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cos_arb_pkg.sv
// rtl/cos_arb_pkg.sv - shared constants, tag type and helpers for the cosine LUT arbiter
package cos_arb_pkg;
  localparam int REQ_N = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] id;
  } tag_t;

  function automatic logic [REQ_N-1:0] id_onehot(input logic [SEL_W-1:0] id);
    logic [REQ_N-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/cos_tag_pipe.sv
// rtl/cos_tag_pipe.sv - LAT-deep shift register tracking which requester owns each LUT read
module cos_tag_pipe import cos_arb_pkg::*; #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rstn,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  tag_t stage_q [LAT];
  tag_t stage_d [LAT];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    any_valid = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[LAT-1];

endmodule

// File: rtl/cos_lut_arbiter.sv
// rtl/cos_lut_arbiter.sv - round-robin sharing of one cosine LUT among four requesters
// Optional per-requester grant counters when COS_ARB_STATS_EN is defined.
module cos_lut_arbiter import cos_arb_pkg::*; #(
  parameter int DATA_W  = 16,
  parameter int LUT_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [REQ_N-1:0]  req,
  output logic [REQ_N-1:0]  gnt,
  output logic [SEL_W-1:0]  lut_sel,
  output logic              lut_en,
  input  logic [DATA_W-1:0] lut_data,
  output logic [REQ_N-1:0]  rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
`ifdef COS_ARB_STATS_EN
  ,
  output logic [REQ_N*CNT_W-1:0] grant_cnt
`endif
);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  lut_sel_q, lut_sel_d;
  logic              lut_en_q, lut_en_d;
  logic [REQ_N-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [SEL_W-1:0]  cand, win;
  logic              found, accept;
  tag_t              tag_in, tag_tail;
  logic              tags_busy;

  // Search from ptr upward (mod 4); the first raised request wins.
  always_comb begin
    cand  = ptr_q;
    win   = ptr_q;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < REQ_N; k++) begin
      cand = ptr_q + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (found) gnt = id_onehot(win);
    accept = |(req & gnt);
  end

  always_comb begin
    ptr_d       = accept ? win + SEL_W'(1) : ptr_q;
    lut_en_d    = accept;
    lut_sel_d   = accept ? win : lut_sel_q;
    rsp_valid_d = tag_tail.valid ? id_onehot(tag_tail.id) : '0;
    rsp_data_d  = tag_tail.valid ? lut_data : rsp_data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q       <= '0;
      lut_sel_q   <= '0;
      lut_en_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      lut_sel_q   <= lut_sel_d;
      lut_en_q    <= lut_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign tag_in = '{valid: lut_en_q, id: lut_sel_q};

  cos_tag_pipe #(.LAT(LUT_LAT)) u_tag_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .tag_in    (tag_in),
    .tag_out   (tag_tail),
    .any_valid (tags_busy)
  );

  assign lut_sel   = lut_sel_q;
  assign lut_en    = lut_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = lut_en_q | tags_busy | (|rsp_valid_q);

`ifdef COS_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [REQ_N];
  logic [CNT_W-1:0] cnt_d [REQ_N];

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    for (int i = 0; i < REQ_N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (req[i] && gnt[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REQ_N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < REQ_N; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_cos_lut_arbiter.sv
// tb/tb_cos_lut_arbiter.sv - scoreboard bench for cos_lut_arbiter at LUT_LAT 2, 1 and 4
module tb_cos_lut_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] req  = '0;
  logic [7:0] addr [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state (written only by the stimulus task).
  int         m_ptr = 0;
  logic       m_en  = 1'b0;
  logic [1:0] m_sel = '0;
  logic [3:0] m_gnt = '0;
  logic       m_acc = 1'b0;
  logic [1:0] m_id  = '0;
  logic [15:0] m_data = '0;
  int         m_cyc = 0;
  logic       exp_en = 1'b0;
  logic [1:0] exp_sel = '0;
  int         m_cnt [4];
  int         exp_cnt [4];
  logic       stats_chk = 1'b0;
  logic [3:0] pend = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rom(input logic [7:0] a);
    return (16'(a) * 16'd251) ^ 16'h3C5A;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h cyc=%0d", name, inst, act, req_v, cyc);
    end
  endtask

  // One clock of stimulus: drive at negedge, then evaluate the round-robin rule.
  task automatic step(input logic [3:0] r, input logic rs);
    bit found;
    int idx;
    @(negedge clk);
    rstn = rs;
    req  = r;
    for (int i = 0; i < 4; i++) begin
      if (!(m_acc && (m_id == 2'(i)))) addr[i] = 8'($urandom);
    end
    #1;
    if (!rstn) begin
      m_ptr = 0;
      m_en  = 1'b0;
      m_sel = '0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end
    exp_en  = m_en;
    exp_sel = m_sel;
    for (int i = 0; i < 4; i++) exp_cnt[i] = (m_cnt[i] > 65535) ? 65535 : m_cnt[i];
    found = 0;
    m_gnt = '0;
    for (int k = 0; k < 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (!found && req[idx]) begin
        found = 1;
        m_id  = 2'(idx);
      end
    end
    if (found) m_gnt = 4'(1 << m_id);
    m_acc  = found && rstn;
    m_data = rom(addr[m_id]);
    m_cyc  = cyc;
    if (m_acc) begin
      m_ptr = (m_id + 1) % 4;
      m_cnt[m_id]++;
      m_sel = m_id;
    end
    m_en = m_acc;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    logic [3:0]  gnt, rsp_valid;
    logic [1:0]  lut_sel;
    logic        lut_en, busy;
    logic [15:0] lut_data, rsp_data;
    logic [15:0] lut_pipe [LAT];
    exp_t        q [$];
    exp_t        e;
    int          last_acc = 0;
    bit          have_acc = 0;
`ifdef COS_ARB_STATS_EN
    logic [63:0] grant_cnt;
`endif

    cos_lut_arbiter #(.DATA_W(16), .LUT_LAT(LAT)) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .req       (req),
      .gnt       (gnt),
      .lut_sel   (lut_sel),
      .lut_en    (lut_en),
      .lut_data  (lut_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy)
`ifdef COS_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
    );

    // LUT with LAT cycles of read latency, addressed through the select mux.
    always @(posedge clk) begin
      lut_pipe[0] <= lut_en ? rom(addr[lut_sel]) : 16'hDEAD;
      for (int i = 1; i < LAT; i++) lut_pipe[i] <= lut_pipe[i-1];
    end
    assign lut_data = lut_pipe[LAT-1];

    always begin
      @(negedge clk);
      #2;
      chk("gnt", g, 32'(gnt), 32'(m_gnt));
      chk("lut_en", g, 32'(lut_en), 32'(exp_en));
      chk("lut_sel", g, 32'(lut_sel), 32'(exp_sel));
      if (m_acc) begin
        q.push_back('{id: m_id, data: m_data, cyc: 32'(m_cyc)});
        last_acc = m_cyc;
        have_acc = 1;
      end
`ifdef COS_ARB_STATS_EN
      if (stats_chk) begin
        for (int i = 0; i < 4; i++) chk("grant_cnt", g, 32'(grant_cnt[i*16 +: 16]), 32'(exp_cnt[i]));
      end
`endif
    end

    always begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        q.delete();
        have_acc = 0;
        chk("rst_rsp_valid", g, 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", g, 32'(rsp_data), 32'd0);
        chk("rst_busy", g, 32'(busy), 32'd0);
      end else begin
        chk("busy", g, 32'(busy), 32'(have_acc && ((cyc - last_acc) <= LAT + 2)));
        if (rsp_valid != 4'd0) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", g, 32'(rsp_valid), 32'd0);
          end else begin
            e = q.pop_front();
            chk("rsp_valid", g, 32'(rsp_valid), 32'(1 << e.id));
            chk("rsp_data", g, 32'(rsp_data), 32'(e.data));
            chk("latency", g, 32'(cyc - int'(e.cyc)), 32'(LAT + 2));
          end
        end else if (q.size() != 0 && (int'(q[0].cyc) + LAT + 2 <= cyc)) begin
          e = q.pop_front();
          chk("missing_rsp", g, 32'(rsp_valid), 32'(1 << e.id));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      addr[i]    = '0;
      m_cnt[i]   = 0;
      exp_cnt[i] = 0;
    end
    #1 rstn = 1'b0;

    // Reset with random requests: gnt still follows req from ptr 0.
    for (int n = 0; n < 4; n++) step(4'($urandom), 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Single-cycle pulse from requester 2, then a full sweep to expose ptr=3.
    step(4'b0100, 1'b1);
    for (int n = 0; n < 7; n++) step(4'b0000, 1'b1);
    for (int n = 0; n < 8; n++) step(4'b1111, 1'b1);
    for (int n = 0; n < 8; n++) step(4'b0000, 1'b1);

    // Alternating pair from a fresh pointer.
    step(4'b0000, 1'b0);
    for (int n = 0; n < 8; n++) step(4'b1010, 1'b1);
    for (int n = 0; n < 8; n++) step(4'b0000, 1'b1);

    // Continuous single requester.
    for (int n = 0; n < 6; n++) step(4'b0001, 1'b1);
    for (int n = 0; n < 8; n++) step(4'b0000, 1'b1);

    // Random traffic; a requester keeps its request up until granted.
    pend = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 3) != 0)) pend[i] = 1'b1;
      end
      step(pend, 1'b1);
      if (m_acc) pend[m_id] = 1'b0;
    end
    stats_chk = 1'b1;
    step(4'b0000, 1'b1);
    stats_chk = 1'b0;
    for (int n = 0; n < 8; n++) step(4'b0000, 1'b1);

    // Reset with reads in flight; nothing may come back afterwards.
    for (int n = 0; n < 3; n++) step(4'b1111, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    for (int n = 0; n < 12; n++) step(4'b0000, 1'b1);

`ifdef COS_ARB_STATS_EN
    step(4'b0000, 1'b0);
    for (int n = 0; n < 70000; n++) step(4'b0100, 1'b1);
    stats_chk = 1'b1;
    step(4'b0000, 1'b1);
    stats_chk = 1'b0;
    for (int n = 0; n < 8; n++) step(4'b0000, 1'b1);
`endif

    for (int n = 0; n < 10; n++) step(4'b0000, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
